// File: rtl/graph_loader_pkg.sv
// Shared types for the graph edge loader: node ids, loader FSM states and error codes.
package graph_loader_pkg;

   typedef logic [31:0] node_id_t;

   typedef enum logic [2:0] {IDLE, LOAD, FINALIZE, READY, ERROR} loader_state_e;

   typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_OVERFLOW} load_err_e;

   // Global node id held by partition p, slot s.
   function automatic node_id_t slot_node(input int p, input int s, input int nodes_in_partition);
      return node_id_t'(p * nodes_in_partition + s);
   endfunction

endpackage

// File: rtl/graph_adj_table.sv
// Partitioned adjacency storage: synchronous clear, edge append and self-loop fix write ports.
module graph_adj_table
   import graph_loader_pkg::*;
#(
   parameter int NUM_PARTITIONS     = 1,
   parameter int NODES_IN_PARTITION = 4,
   parameter int MAX_OUT_DEGREE     = 3
) (
   input  logic     clock,
   input  logic     reset_n,
   input  logic     clear,
   input  logic     append_en,
   input  node_id_t append_src,
   input  node_id_t append_dst,
   input  logic     fix_en,
   input  node_id_t fix_node,
   output node_id_t out_degree [NUM_PARTITIONS][NODES_IN_PARTITION],
   output node_id_t dest_id    [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_OUT_DEGREE]
);

   // Slots are addressed by comparing against their global id, so no divider is needed.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         for (int p = 0; p < NUM_PARTITIONS; p++) begin
            for (int s = 0; s < NODES_IN_PARTITION; s++) begin
               out_degree[p][s] <= '0;
               for (int k = 0; k < MAX_OUT_DEGREE; k++) begin
                  dest_id[p][s][k] <= '0;
               end
            end
         end
      end else begin
         for (int p = 0; p < NUM_PARTITIONS; p++) begin
            for (int s = 0; s < NODES_IN_PARTITION; s++) begin
               if (append_en && append_src == slot_node(p, s, NODES_IN_PARTITION)) begin
                  out_degree[p][s] <= out_degree[p][s] + 32'd1;
                  for (int k = 0; k < MAX_OUT_DEGREE; k++) begin
                     if (out_degree[p][s] == node_id_t'(k)) begin
                        dest_id[p][s][k] <= append_dst;
                     end
                  end
               end else if (fix_en && fix_node == slot_node(p, s, NODES_IN_PARTITION)) begin
                  out_degree[p][s] <= 32'd1;
                  dest_id[p][s][0] <= fix_node;
               end
            end
         end
      end
   end

endmodule

// File: rtl/graph_edge_loader.sv
// Edge-list loader feeding the pagerank engine: FSM, edge handshake and error tracking.
// Optional build macro GRAPH_LOADER_DANGLING_FIX_EN adds self-loops to zero-degree nodes in FINALIZE.
module graph_edge_loader
   import graph_loader_pkg::*;
#(
   parameter int NUM_PARTITIONS     = 1,
   parameter int NODES_IN_PARTITION = 4,
   parameter int NODES_IN_GRAPH     = 4,
   parameter int MAX_OUT_DEGREE     = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load_start,
   input  logic          edge_valid,
   output logic          edge_ready,
   input  logic [31:0]   edge_src,
   input  logic [31:0]   edge_dst,
   input  logic          edge_last,
   output logic [31:0]   source_id  [NUM_PARTITIONS][NODES_IN_PARTITION],
   output logic [31:0]   out_degree [NUM_PARTITIONS][NODES_IN_PARTITION],
   output logic [31:0]   dest_id    [NUM_PARTITIONS][NODES_IN_PARTITION][MAX_OUT_DEGREE],
   output logic          pagerank_enable,
   output logic          load_error,
   output logic [1:0]    error_code,
   output logic [31:0]   edge_count,
   output loader_state_e state_dbg
);

   // Handshake: an edge transfers on a posedge where edge_valid && edge_ready; the host
   // holds src/dst/last stable while edge_valid=1 and edge_ready=0.
   loader_state_e state, state_next;
   load_err_e     edge_err;
   logic          xfer, append_en, fix_en, scan_done;
   node_id_t      src_degree, fix_node;

   assign edge_ready      = (state == LOAD) && !load_start;
   assign xfer            = edge_valid && edge_ready;
   assign pagerank_enable = (state == READY);
   assign state_dbg       = state;

   always_comb begin
      for (int p = 0; p < NUM_PARTITIONS; p++) begin
         for (int s = 0; s < NODES_IN_PARTITION; s++) begin
            source_id[p][s] = slot_node(p, s, NODES_IN_PARTITION);
         end
      end
   end

   always_comb begin
      src_degree = '0;
      for (int p = 0; p < NUM_PARTITIONS; p++) begin
         for (int s = 0; s < NODES_IN_PARTITION; s++) begin
            if (edge_src == slot_node(p, s, NODES_IN_PARTITION)) src_degree = out_degree[p][s];
         end
      end
   end

   always_comb begin
      edge_err = ERR_NONE;
      if (edge_src >= node_id_t'(NODES_IN_GRAPH) || edge_dst >= node_id_t'(NODES_IN_GRAPH)) begin
         edge_err = ERR_RANGE;
      end else if (src_degree == node_id_t'(MAX_OUT_DEGREE)) begin
         edge_err = ERR_OVERFLOW;
      end
   end

   assign append_en = xfer && (edge_err == ERR_NONE);

`ifdef GRAPH_LOADER_DANGLING_FIX_EN
   node_id_t scan_idx, scan_degree;

   // One node per FINALIZE cycle; the index restarts whenever FINALIZE is entered.
   always_ff @(posedge clock) begin
      if (!reset_n || state != FINALIZE) scan_idx <= '0;
      else                               scan_idx <= scan_idx + 32'd1;
   end

   always_comb begin
      scan_degree = '0;
      for (int p = 0; p < NUM_PARTITIONS; p++) begin
         for (int s = 0; s < NODES_IN_PARTITION; s++) begin
            if (scan_idx == slot_node(p, s, NODES_IN_PARTITION)) scan_degree = out_degree[p][s];
         end
      end
   end

   assign fix_node  = scan_idx;
   assign fix_en    = (state == FINALIZE) && (scan_degree == '0);
   assign scan_done = (scan_idx == node_id_t'(NODES_IN_GRAPH - 1));
`else
   assign fix_node  = '0;
   assign fix_en    = 1'b0;
   assign scan_done = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load_start) begin
         state_next = LOAD;
      end else begin
         case (state)
            LOAD:     if (xfer && edge_last) state_next = FINALIZE;
            FINALIZE: if (scan_done) state_next = load_error ? ERROR : READY;
            default:  ;
         endcase
      end
   end

   // Only the first error of a load is latched; later edges keep flowing until edge_last.
   always_ff @(posedge clock) begin
      if (!reset_n || load_start) begin
         edge_count <= '0;
         load_error <= 1'b0;
         error_code <= ERR_NONE;
      end else if (xfer) begin
         if (edge_err == ERR_NONE) begin
            edge_count <= edge_count + 32'd1;
         end else if (!load_error) begin
            load_error <= 1'b1;
            error_code <= edge_err;
         end
      end
   end

   graph_adj_table #(
      .NUM_PARTITIONS     (NUM_PARTITIONS),
      .NODES_IN_PARTITION (NODES_IN_PARTITION),
      .MAX_OUT_DEGREE     (MAX_OUT_DEGREE)
   ) u_table (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (load_start),
      .append_en  (append_en),
      .append_src (edge_src),
      .append_dst (edge_dst),
      .fix_en     (fix_en),
      .fix_node   (fix_node),
      .out_degree (out_degree),
      .dest_id    (dest_id)
   );

endmodule

// File: tb/tb_graph_edge_loader.sv
// Directed bench for graph_edge_loader: behavioural table model plus a queue of expected stored destinations.
module tb_graph_edge_loader;
   import graph_loader_pkg::*;

   localparam int NP  = 1;
   localparam int NIP = 4;
   localparam int NIG = 4;
   localparam int MOD = 3;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          load_start = 1'b0;
   logic          edge_valid = 1'b0;
   logic          edge_last = 1'b0;
   logic [31:0]   edge_src = '0;
   logic [31:0]   edge_dst = '0;
   logic          edge_ready;
   logic [31:0]   source_id  [NP][NIP];
   logic [31:0]   out_degree [NP][NIP];
   logic [31:0]   dest_id    [NP][NIP][MOD];
   logic          pagerank_enable;
   logic          load_error;
   logic [1:0]    error_code;
   logic [31:0]   edge_count;
   loader_state_e state_dbg;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   int          m_deg [NIG];
   int          m_dest [NIG][MOD];
   int          m_cnt;
   int          m_err;

   graph_edge_loader #(
      .NUM_PARTITIONS     (NP),
      .NODES_IN_PARTITION (NIP),
      .NODES_IN_GRAPH     (NIG),
      .MAX_OUT_DEGREE     (MOD)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .load_start      (load_start),
      .edge_valid      (edge_valid),
      .edge_ready      (edge_ready),
      .edge_src        (edge_src),
      .edge_dst        (edge_dst),
      .edge_last       (edge_last),
      .source_id       (source_id),
      .out_degree      (out_degree),
      .dest_id         (dest_id),
      .pagerank_enable (pagerank_enable),
      .load_error      (load_error),
      .error_code      (error_code),
      .edge_count      (edge_count),
      .state_dbg       (state_dbg)
   );

   // Clock and watchdog
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Reference model
   task automatic model_clear();
      for (int n = 0; n < NIG; n++) begin
         m_deg[n] = 0;
         for (int k = 0; k < MOD; k++) m_dest[n][k] = 0;
      end
      m_cnt = 0;
      m_err = 0;
      exp_q.delete();
   endtask

   function automatic bit model_edge(input int src, input int dst);
      if (src >= NIG || dst >= NIG) begin
         if (m_err == 0) m_err = 1;
         return 1'b0;
      end
      if (m_deg[src] == MOD) begin
         if (m_err == 0) m_err = 2;
         return 1'b0;
      end
      m_dest[src][m_deg[src]] = dst;
      m_deg[src]++;
      m_cnt++;
      exp_q.push_back(32'(dst));
      return 1'b1;
   endfunction

   task automatic model_finalize();
`ifdef GRAPH_LOADER_DANGLING_FIX_EN
      for (int n = 0; n < NIG; n++) begin
         if (m_deg[n] == 0) begin
            m_deg[n] = 1;
            m_dest[n][0] = n;
         end
      end
`endif
   endtask

   task automatic check_tables(input string tag);
      for (int n = 0; n < NIG; n++) begin
         check($sformatf("%s out_degree[%0d]", tag, n), out_degree[n / NIP][n % NIP], 32'(m_deg[n]));
         for (int k = 0; k < MOD; k++) begin
            check($sformatf("%s dest_id[%0d][%0d]", tag, n, k), dest_id[n / NIP][n % NIP][k],
                  32'(m_dest[n][k]));
         end
      end
      check({tag, " edge_count"}, edge_count, 32'(m_cnt));
      check({tag, " load_error"}, 32'(load_error), 32'(m_err != 0));
      check({tag, " error_code"}, 32'(error_code), 32'(m_err));
   endtask

   task automatic check_reset(input string tag);
      check({tag, " state"}, 32'(state_dbg), 32'(IDLE));
      check({tag, " edge_ready"}, 32'(edge_ready), 32'd0);
      check({tag, " pagerank_enable"}, 32'(pagerank_enable), 32'd0);
      for (int n = 0; n < NP * NIP; n++) begin
         check($sformatf("%s source_id[%0d]", tag, n), source_id[n / NIP][n % NIP], 32'(n));
      end
      model_clear();
      check_tables(tag);
   endtask

   // Driver tasks: entered and left at a negedge
   task automatic start_load();
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
      model_clear();
      check("state after load_start", 32'(state_dbg), 32'(LOAD));
   endtask

   task automatic send_edge(input int src, input int dst, input bit last);
      bit          acc;
      int          old;
      logic [31:0] exp;
      edge_valid = 1'b1;
      edge_src   = 32'(src);
      edge_dst   = 32'(dst);
      edge_last  = last;
      #1;
      check("edge_ready in LOAD", 32'(edge_ready), 32'd1);
      old = (src < NIG) ? m_deg[src] : 0;
      acc = model_edge(src, dst);
      @(negedge clock);
      edge_valid = 1'b0;
      edge_last  = 1'b0;
      if (acc) begin
         exp = exp_q.pop_front();
         check($sformatf("stored dest of %0d", src), dest_id[src / NIP][src % NIP][old], exp);
      end
      check("edge_count after edge", edge_count, 32'(m_cnt));
   endtask

   // Holds edge_valid with changing data through FINALIZE, then checks the end state.
   task automatic wait_finalize(input loader_state_e exp_end);
      int cycles = 1;
`ifdef GRAPH_LOADER_DANGLING_FIX_EN
      cycles = NIG;
`endif
      for (int i = 0; i < cycles; i++) begin
         edge_valid = 1'b1;
         edge_src   = 32'($urandom_range(0, NIG - 1));
         edge_dst   = 32'($urandom_range(0, NIG - 1));
         #1;
         check("state in FINALIZE", 32'(state_dbg), 32'(FINALIZE));
         check("edge_ready in FINALIZE", 32'(edge_ready), 32'd0);
         check("pagerank_enable in FINALIZE", 32'(pagerank_enable), 32'd0);
         @(negedge clock);
      end
      edge_valid = 1'b0;
      model_finalize();
      check("state after FINALIZE", 32'(state_dbg), 32'(exp_end));
      check("pagerank_enable after FINALIZE", 32'(pagerank_enable), 32'(exp_end == READY));
   endtask

   initial begin
      model_clear();

      // Reset
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check_reset("reset");
      reset_n = 1'b1;
      @(negedge clock);
      check("idle holds", 32'(state_dbg), 32'(IDLE));

      // Nominal load
      start_load();
      send_edge(0, 1, 1'b0);
      send_edge(0, 2, 1'b0);
      send_edge(1, 3, 1'b0);
      send_edge(2, 0, 1'b0);
      send_edge(2, 1, 1'b0);
      send_edge(2, 3, 1'b0);
      send_edge(3, 2, 1'b1);
      wait_finalize(READY);
      check_tables("nominal");
      check("nominal edge_count", edge_count, 32'd7);

      // Backpressure in READY
      for (int i = 0; i < 3; i++) begin
         edge_valid = 1'b1;
         edge_src   = 32'($urandom_range(0, NIG - 1));
         edge_dst   = 32'($urandom_range(0, NIG - 1));
         edge_last  = 1'($urandom_range(0, 1));
         #1;
         check("edge_ready in READY", 32'(edge_ready), 32'd0);
         @(negedge clock);
      end
      edge_valid = 1'b0;
      edge_last  = 1'b0;
      check("state holds READY", 32'(state_dbg), 32'(READY));
      check_tables("ready hold");

      // Degree overflow
      start_load();
      check_tables("cleared");
      send_edge(1, 0, 1'b0);
      send_edge(1, 2, 1'b0);
      send_edge(1, 3, 1'b0);
      send_edge(1, 0, 1'b1);
      wait_finalize(ERROR);
      check_tables("overflow");
      check("overflow error_code", 32'(error_code), 32'd2);

      // Range error followed by a good edge
      start_load();
      send_edge(5, 0, 1'b0);
      send_edge(0, 1, 1'b1);
      wait_finalize(ERROR);
      check_tables("range");
      check("range error_code", 32'(error_code), 32'd1);

      // load_start mid-LOAD beats a simultaneous edge
      start_load();
      send_edge(0, 1, 1'b0);
      send_edge(0, 2, 1'b0);
      load_start = 1'b1;
      edge_valid = 1'b1;
      edge_src   = 32'd3;
      edge_dst   = 32'd3;
      #1;
      check("edge_ready during load_start", 32'(edge_ready), 32'd0);
      @(negedge clock);
      load_start = 1'b0;
      edge_valid = 1'b0;
      model_clear();
      check("state after restart", 32'(state_dbg), 32'(LOAD));
      check_tables("restart");
      send_edge(2, 3, 1'b1);
      wait_finalize(READY);
      check_tables("after restart");

      // Reset in READY
      reset_n = 1'b0;
      @(negedge clock);
      check_reset("reset in READY");
      reset_n = 1'b1;
      @(negedge clock);

`ifdef GRAPH_LOADER_DANGLING_FIX_EN
      // Dangling nodes get self-loops
      start_load();
      send_edge(0, 1, 1'b1);
      wait_finalize(READY);
      check_tables("dangling");
      check("dangling edge_count", edge_count, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
